// File: rtl/pipe_ctrl_if.sv
// Shared memory port bundle between pipe_ctrl (master) and the memory (slave).
// Signal names keep the controller's point of view.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              port_req_o;
    logic              port_we_o;
    logic [ADDR_W-1:0] port_addr_o;
    logic [DATA_W-1:0] port_wdata_o;
    logic [DATA_W-1:0] port_rdata_i;
    logic              port_done_i;

    modport master (
        output port_req_o,
        output port_we_o,
        output port_addr_o,
        output port_wdata_o,
        input  port_rdata_i,
        input  port_done_i
    );

    modport slave (
        input  port_req_o,
        input  port_we_o,
        input  port_addr_o,
        input  port_wdata_o,
        output port_rdata_i,
        output port_done_i
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: IF/MEM memory port arbiter, stall vector and flush control.
// Define PIPE_CTRL_RR_ARB_EN for round-robin arbitration (default: fixed MEM priority).
module pipe_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_i,
    input  logic [ADDR_W-1:0]  if_addr_i,
    input  logic               mem_req_i,
    input  logic               mem_we_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic               id_stallreq_i,
    input  logic               ex_b_flag_i,
    pipe_ctrl_if.master        port,
    output logic               if_done_o,
    output logic               mem_done_o,
    output logic [DATA_W-1:0]  rdata_o,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        MEM_BUSY
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_flush_pend;
    logic              r_port_req;
    logic              r_port_we;
    logic [ADDR_W-1:0] r_port_addr;
    logic [DATA_W-1:0] r_port_wdata;
    logic              w_grant_if;
    logic              w_grant_mem;
    logic              w_if_busy;
    logic              w_done;

`ifdef PIPE_CTRL_RR_ARB_EN
    logic r_last_mem;
`endif

    assign w_done    = port.port_done_i;
    assign w_if_busy = (r_state == IF_BUSY);

    always_comb begin
        w_next      = r_state;
        w_grant_if  = 1'b0;
        w_grant_mem = 1'b0;
        unique case (r_state)
            IDLE: begin
`ifdef PIPE_CTRL_RR_ARB_EN
                if (mem_req_i && if_req_i) begin
                    w_grant_mem = ~r_last_mem;
                    w_grant_if  = r_last_mem;
                end else begin
                    w_grant_mem = mem_req_i;
                    w_grant_if  = if_req_i;
                end
`else
                w_grant_mem = mem_req_i;
                w_grant_if  = if_req_i & ~mem_req_i;
`endif
                if (w_grant_mem)
                    w_next = MEM_BUSY;
                else if (w_grant_if)
                    w_next = IF_BUSY;
            end
            IF_BUSY, MEM_BUSY: begin
                if (w_done)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // A branch in the done cycle also kills the fetch, without arming the swallow.
    assign if_done_o  = w_if_busy & w_done & ~r_flush_pend & ~ex_b_flag_i;
    assign mem_done_o = (r_state == MEM_BUSY) & w_done;
    assign rdata_o    = port.port_rdata_i;
    assign flush_o    = ex_b_flag_i;

    always_comb begin
        stall_o = '0;
        if (mem_req_i && !mem_done_o)
            stall_o = STALL_W'(6'b011111);
        else if (id_stallreq_i)
            stall_o = STALL_W'(6'b000111);
        else if (if_req_i && !if_done_o)
            stall_o = STALL_W'(6'b000011);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_flush_pend <= 1'b0;
            r_port_req   <= 1'b0;
            r_port_we    <= 1'b0;
            r_port_addr  <= '0;
            r_port_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_mem) begin
                r_port_req   <= 1'b1;
                r_port_we    <= mem_we_i;
                r_port_addr  <= mem_addr_i;
                r_port_wdata <= mem_wdata_i;
            end else if (w_grant_if) begin
                r_port_req  <= 1'b1;
                r_port_we   <= 1'b0;
                r_port_addr <= if_addr_i;
            end else if (r_state != IDLE && w_done) begin
                r_port_req <= 1'b0;
                r_port_we  <= 1'b0;
            end
            if (w_if_busy && w_done)
                r_flush_pend <= 1'b0;
            else if (ex_b_flag_i && (w_if_busy || w_grant_if))
                r_flush_pend <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_RR_ARB_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_last_mem <= 1'b0;
        else if (w_grant_mem)
            r_last_mem <= 1'b1;
        else if (w_grant_if)
            r_last_mem <= 1'b0;
    end
`endif

    assign port.port_req_o   = r_port_req;
    assign port.port_we_o    = r_port_we;
    assign port.port_addr_o  = r_port_addr;
    assign port.port_wdata_o = r_port_wdata;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencer for the five-stage RISC-V core.
- Arbitrates the single shared memory port between instruction fetch (IF) and load/store (MEM).
- Generates the 6-bit stall vector consumed by the pc/if_id/id_ex/ex_mem/mem_wb registers.
- Sequences branch flushes, including discarding an in-flight fetch that a taken branch made stale.

Parameters:
ADDR_W, 32, address width of memory port and requesters
DATA_W, 32, data width of memory port
STALL_W, 6, stall vector width; bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
if_req_i  in  1  IF wants a fetch; held until if_done_o
if_addr_i  in  ADDR_W  fetch address, stable while if_req_i
mem_req_i  in  1  MEM wants a load/store; held until mem_done_o
mem_we_i  in  1  1 = store
mem_addr_i  in  ADDR_W  load/store address
mem_wdata_i  in  DATA_W  store data
id_stallreq_i  in  1  load-use hazard from ID
ex_b_flag_i  in  1  branch/jump taken, resolved in EX
port_req_o  out  1  memory port request
port_we_o  out  1  memory port write enable
port_addr_o  out  ADDR_W  memory port address
port_wdata_o  out  DATA_W  memory port write data
port_rdata_i  in  DATA_W  memory read data, valid with port_done_i
port_done_i  in  1  one-cycle completion pulse
if_done_o  out  1  fetch complete, instruction valid
mem_done_o  out  1  load/store complete
rdata_o  out  DATA_W  port_rdata_i passthrough
stall_o  out  STALL_W  stall vector
flush_o  out  1  flush if_id and id_ex this cycle

Behaviour:
- Reset: state IDLE; port_req_o=0, port_we_o=0, port_addr_o=0, port_wdata_o=0; flush_pending=0; last_grant=IF. Combinational outputs follow from that state.
- Reset is honoured mid-transaction. The active request is abandoned, and the memory must tolerate port_req_o dropping.
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
  - IDLE with mem_req_i -> MEM_BUSY. MEM has fixed priority when both requests are present.
  - IDLE with only if_req_i -> IF_BUSY.
  - IDLE with no request stays IDLE.
  - *_BUSY with port_done_i -> IDLE. No back-to-back grant: at least one IDLE cycle between transactions.
  - No preemption. Requester inputs are ignored while BUSY.
- port_* outputs are registered on entry to BUSY (1-cycle request latency) and held constant until done.
- if_done_o = (state==IF_BUSY) & port_done_i & ~flush_pending.
- mem_done_o = (state==MEM_BUSY) & port_done_i.
- rdata_o is always port_rdata_i.
- Stall vector is combinational, highest priority first:
  1. mem_req_i & ~mem_done_o -> 6'b011111
  2. id_stallreq_i -> 6'b000111
  3. if_req_i & ~if_done_o -> 6'b000011
  4. otherwise 6'b000000
- Flush:
  - flush_o = ex_b_flag_i, same cycle.
  - flush_pending is set when ex_b_flag_i and (state==IF_BUSY & ~port_done_i, or IDLE granting IF this cycle).
  - flush_pending clears on port_done_i in IF_BUSY.
  - While flush_pending, the completing fetch is swallowed: if_done_o=0 and stall bit1 stays set. IF must re-request with the new pc.
- ex_b_flag_i in the same cycle as the IF port_done_i: if_done_o=0 and flush_pending is not set.
- ex_b_flag_i while MEM_BUSY: flush_o asserts and flush_pending is unchanged.

Optional Feature:
- Macro: PIPE_CTRL_RR_ARB_EN.
- Defined: when both requests are seen in IDLE, grant goes to the requester other than last_grant. last_grant updates on each grant.
- Undefined: fixed MEM priority, and last_grant is not implemented.

Test Plan:
- Reset with rst=1 over 2 cycles -> state IDLE, port_req_o=0, stall_o=6'b000000, flush_o=0.
- if_req_i=1, addr 0x100; port_done_i 3 cycles after port_req_o, rdata 0x00500093 -> port_req_o rises 1 cycle after if_req_i; stall_o=6'b000011 until done; if_done_o=1 with rdata_o=0x00500093.
- mem_req_i and if_req_i rise together, load addr 0x200 -> MEM granted first with stall_o=6'b011111; IF granted after one IDLE cycle.
- IF in flight; ex_b_flag_i pulses 1 cycle before port_done_i -> flush_o=1 that cycle; at done if_done_o=0; the next fetch to the branch target completes normally.
- id_stallreq_i=1 with no memory activity -> stall_o=6'b000111. Adding mem_req_i -> stall_o=6'b011111.
- PIPE_CTRL_RR_ARB_EN defined, both requests present in IDLE for two transactions -> grants alternate MEM, IF. Undefined -> MEM wins both.
